// File: rtl/stack_unit.sv
// LIFO stack with registered pop port, push/pop swap and overflow/underflow flags.
// Define STACK_ERR_STICKY_EN to make ovf/unf hold until reset instead of pulsing.
module stack_unit #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psh,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     pop_valid,
    output logic [DATA_W-1:0]        top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     sp;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_addr;
    logic              wr_en;
    logic              ovf_evt;
    logic              unf_evt;

    // Low bits of sp minus one wrap sp==DEPTH onto the last entry.
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign count   = sp;
    assign empty   = (sp == '0);
    assign full    = (sp == CW'(DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    assign ovf_evt = psh && !pop && full;
    assign unf_evt = pop && !psh && empty;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp[AW-1:0];
        if (psh && pop && !empty) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (psh && !pop && !full) begin
            wr_en = 1'b1;
        end
    end

    // Storage is deliberately not reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_addr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            case ({psh, pop})
                2'b10: if (!full) sp <= sp + CW'(1);
                2'b01: begin
                    if (!empty) begin
                        pop_data  <= mem[top_idx];
                        pop_valid <= 1'b1;
                        sp        <= sp - CW'(1);
                    end
                end
                2'b11: begin
                    pop_data  <= empty ? push_data : mem[top_idx];
                    pop_valid <= 1'b1;
                end
                default: ;
            endcase
`ifdef STACK_ERR_STICKY_EN
            ovf <= ovf | ovf_evt;
            unf <= unf | unf_evt;
`else
            ovf <= ovf_evt;
            unf <= unf_evt;
`endif
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_stack_unit;

    localparam int DW = 16;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst, psh, pop;
    logic [DW-1:0] push_data;
    logic [DW-1:0] pop_data, top;
    logic          pop_valid, empty, full, ovf, unf;
    logic [4:0]    count;

    int compared   = 0;
    int mismatched = 0;

    stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .psh(psh), .pop(pop), .push_data(push_data),
        .pop_data(pop_data), .pop_valid(pop_valid), .top(top), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Reference model: a queue whose back is the top of stack.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_pd;
    logic          m_pv, m_ovf, m_unf, m_ok;
    initial m_ok = 1'b0;

    always @(posedge clk) begin
        logic oe, ue;
        oe = 1'b0;
        ue = 1'b0;
        if (rst) begin
            q.delete();
            m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_ok = 1'b1;
        end else begin
            m_pv = 1'b0;
            if (psh && pop) begin
                if (q.size() == 0) m_pd = push_data;
                else begin
                    m_pd = q.pop_back();
                    q.push_back(push_data);
                end
                m_pv = 1'b1;
            end else if (psh) begin
                if (q.size() == DP) oe = 1'b1;
                else q.push_back(push_data);
            end else if (pop) begin
                if (q.size() == 0) ue = 1'b1;
                else begin
                    m_pd = q.pop_back();
                    m_pv = 1'b1;
                end
            end
`ifdef STACK_ERR_STICKY_EN
            m_ovf = m_ovf | oe;
            m_unf = m_unf | ue;
`else
            m_ovf = oe;
            m_unf = ue;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_pop_data",  32'(pop_data),  32'(m_pd));
            chk("m_pop_valid", 32'(pop_valid), 32'(m_pv));
            chk("m_top",       32'(top),       (q.size() == 0) ? 32'd0 : 32'(q[$]));
            chk("m_count",     32'(count),     32'(q.size()));
            chk("m_empty",     32'(empty),     32'(q.size() == 0));
            chk("m_full",      32'(full),      32'(q.size() == DP));
            chk("m_ovf",       32'(ovf),       32'(m_ovf));
            chk("m_unf",       32'(unf),       32'(m_unf));
        end
    end

    // Drive at a falling edge, return at the next falling edge with results settled.
    task automatic cyc(input logic p, input logic o, input logic [DW-1:0] d);
        psh = p; pop = o; push_data = d;
        @(negedge clk);
    endtask

`ifdef STACK_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    initial begin
        rst = 1'b1; psh = 1'b0; pop = 1'b0; push_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_top",   32'(top), 0);
        chk("rst_pv",    32'(pop_valid), 0);
        rst = 1'b0;

        cyc(1, 0, 16'h0001); cyc(1, 0, 16'h0002); cyc(1, 0, 16'h0003);
        chk("p3_count", 32'(count), 3);
        chk("p3_top",   32'(top), 32'h3);
        chk("p3_empty", 32'(empty), 0);
        chk("p3_full",  32'(full), 0);

        for (int i = 3; i >= 1; i--) begin
            cyc(0, 1, '0);
            chk("pop_data", 32'(pop_data), 32'(i));
            chk("pop_pv",   32'(pop_valid), 1);
        end
        chk("pop_count", 32'(count), 0);
        chk("pop_empty", 32'(empty), 1);
        cyc(0, 0, '0);
        chk("idle_pv", 32'(pop_valid), 0);

        for (int i = 0; i < DP; i++) cyc(1, 0, 16'(16'h0100 + i));
        chk("fill_full",  32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_top",   32'(top), 32'h010F);
        cyc(1, 0, 16'hBEEF);
        chk("ovf_set",   32'(ovf), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_top",   32'(top), 32'h010F);
        cyc(0, 0, '0);
        chk("ovf_after", 32'(ovf), 32'(STICKY));

        cyc(1, 1, 16'h7777);
        chk("swapf_pd",    32'(pop_data), 32'h010F);
        chk("swapf_top",   32'(top), 32'h7777);
        chk("swapf_count", 32'(count), 16);

        for (int i = 0; i < DP; i++) cyc(0, 1, '0);
        chk("drain_pd", 32'(pop_data), 32'h0100);
        cyc(0, 1, '0);
        chk("unf_set", 32'(unf), 1);
        chk("unf_pv",  32'(pop_valid), 0);
        chk("unf_pd",  32'(pop_data), 32'h0100);

        cyc(1, 1, 16'h1234);
        chk("byp_pd",    32'(pop_data), 32'h1234);
        chk("byp_pv",    32'(pop_valid), 1);
        chk("byp_count", 32'(count), 0);
        chk("byp_unf",   32'(unf), 32'(STICKY));

        cyc(1, 0, 16'h00AA);
        cyc(1, 1, 16'h0055);
        chk("swap_pd",    32'(pop_data), 32'h00AA);
        chk("swap_top",   32'(top), 32'h0055);
        chk("swap_count", 32'(count), 1);

        rst = 1'b1;
        cyc(1, 0, 16'h9999);
        rst = 1'b0;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_pv",    32'(pop_valid), 0);
        chk("rst2_ovf",   32'(ovf), 0);
        chk("rst2_unf",   32'(unf), 0);
        cyc(1, 0, 16'h0042);
        chk("rst2_push_top",   32'(top), 32'h0042);
        chk("rst2_push_count", 32'(count), 1);

        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 16'($urandom));

        cyc(0, 0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
